// File: rtl/frame_reader_pkg.sv
// Shared defaults and FSM encoding for the frame reader.
package frame_reader_pkg;

  localparam int unsigned ADDR_W_DEFAULT = 8;
  localparam int unsigned DATA_W_DEFAULT = 16;
  localparam int unsigned FRAME_LEN      = 1 << ADDR_W_DEFAULT;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StRead  = 2'd1,
    StDrain = 2'd2
  } state_e;

endpackage

// File: rtl/frame_reader_skid_buffer.sv
// Two-entry output buffer: absorbs the RAM read pipeline while the consumer stalls.
module skid_buffer #(
  parameter int unsigned Width = 25
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  logic [Width-1:0] push_data_i,
  input  logic             pop_ready_i,
  output logic [Width-1:0] data_o,
  output logic             valid_o,
  output logic [1:0]       level_o
);

  logic [Width-1:0] head_q, head_d;
  logic [Width-1:0] tail_q, tail_d;
  logic [1:0]       level_q, level_d;
  logic             pop;

  assign valid_o = (level_q != 2'd0);
  assign pop     = valid_o & pop_ready_i;
  assign data_o  = head_q;
  assign level_o = level_q;

  // Next-state for the two entries; head only changes on a push into empty or on a pop.
  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    level_d = level_q;
    case ({push_i, pop})
      2'b10: begin
        if (level_q == 2'd0) head_d = push_data_i;
        else                 tail_d = push_data_i;
        level_d = level_q + 2'd1;
      end
      2'b01: begin
        head_d  = tail_q;
        level_d = level_q - 2'd1;
      end
      2'b11: begin
        if (level_q == 2'd1) begin
          head_d = push_data_i;
        end else begin
          head_d = tail_q;
          tail_d = push_data_i;
        end
      end
      default: ;
    endcase
  end

  // Entry and occupancy registers with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      head_q  <= '0;
      tail_q  <= '0;
      level_q <= 2'd0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      level_q <= level_d;
    end
  end

endmodule

// File: rtl/frame_reader.sv
// Reads one frame out of sample RAM (optionally bit-reversed) into a flow-controlled stream.
module frame_reader
  import frame_reader_pkg::*;
#(
  parameter int unsigned ADDR_W      = ADDR_W_DEFAULT,
  parameter int unsigned DATA_W      = DATA_W_DEFAULT,
  parameter int unsigned BIT_REVERSE = 1
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              FRAME_READY,
  output logic [ADDR_W-1:0] RADDR,
  output logic              RE,
  input  logic [DATA_W-1:0] RDATA,
  output logic [DATA_W-1:0] DATA_OUT,
  output logic              DV,
  input  logic              READY,
  output logic [ADDR_W-1:0] INDEX,
  output logic              LAST,
  output logic              BUSY,
  output logic              OVERRUN
);

  localparam int unsigned       EntryW  = DATA_W + ADDR_W + 1;
  localparam logic [ADDR_W-1:0] LastIdx = '1;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] count_q, count_d;
  logic [ADDR_W-1:0] count_rev;
  logic              pending_q, pending_d;
  logic              overrun_q, overrun_d;
  logic              infl_q;
  logic [ADDR_W-1:0] infl_idx_q;
  logic [1:0]        buf_level;
  logic [2:0]        outstanding;
  logic [EntryW-1:0] push_data, buf_data;
  logic              head_last;
  logic              busy;
  logic              xfer, last_xfer, issue;

  // Bit-reversed view of the read counter.
  always_comb begin
    count_rev = '0;
    for (int i = 0; i < ADDR_W; i++) count_rev[i] = count_q[ADDR_W-1-i];
  end

  assign busy        = (state_q != StIdle);
  assign xfer        = DV & READY;
  assign last_xfer   = xfer & LAST;
  // A read may be issued only if its sample is guaranteed a buffer slot.
  assign outstanding = {1'b0, buf_level} + {2'b00, infl_q};
  assign issue       = (state_q == StRead) && (outstanding < (3'd2 + {2'b00, xfer}));

  assign RE      = issue;
  assign RADDR   = (BIT_REVERSE != 0) ? count_rev : count_q;
  assign BUSY    = busy;
  assign OVERRUN = overrun_q;

  // Frame sequencing, pending request bookkeeping and overrun detection.
  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    pending_d = pending_q;
    overrun_d = 1'b0;
    if (FRAME_READY && busy) begin
      if (pending_q) overrun_d = 1'b1;
      else           pending_d = 1'b1;
    end
    case (state_q)
      StIdle: begin
        if (FRAME_READY || pending_q) begin
          state_d   = StRead;
          count_d   = '0;
          pending_d = 1'b0;
        end
      end
      StRead: begin
        if (issue) begin
          if (count_q == LastIdx) state_d = StDrain;
          else                    count_d = count_q + 1'b1;
        end
      end
      StDrain: begin
        if (last_xfer) begin
          // A request arriving with the last transfer chains straight into the next frame.
          if (pending_q || FRAME_READY) begin
            state_d   = StRead;
            count_d   = '0;
            pending_d = 1'b0;
          end else begin
            state_d = StIdle;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Control state plus the one-deep record of the read in flight.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q    <= StIdle;
      count_q    <= '0;
      pending_q  <= 1'b0;
      overrun_q  <= 1'b0;
      infl_q     <= 1'b0;
      infl_idx_q <= '0;
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      pending_q  <= pending_d;
      overrun_q  <= overrun_d;
      infl_q     <= issue;
      infl_idx_q <= count_q;
    end
  end

  assign push_data = {(infl_idx_q == LastIdx), infl_idx_q, RDATA};

  skid_buffer #(
    .Width(EntryW)
  ) u_skid (
    .clk_i      (CLK),
    .rst_i      (RESET),
    .push_i     (infl_q),
    .push_data_i(push_data),
    .pop_ready_i(READY),
    .data_o     (buf_data),
    .valid_o    (DV),
    .level_o    (buf_level)
  );

  assign {head_last, INDEX, DATA_OUT} = buf_data;
  assign LAST = DV & head_last;

endmodule

// File: tb/tb_frame_reader.sv
module tb_frame_reader;

  logic CLK = 1'b0;
  logic RESET, FRAME_READY, READY;

  logic [7:0]  r_raddr, n_raddr, r_index, n_index;
  logic        r_re, n_re, r_dv, n_dv, r_last, n_last, r_busy, n_busy, r_ovr, n_ovr;
  logic [15:0] r_rdata, n_rdata, r_dout, n_dout;

  logic [15:0] mem [256];

  int checks = 0;
  int errors = 0;
  int ready_mode = 0;  // 0 hold, 1 toggle, 2 random (mostly high)

  int          exp_idx [2];
  logic        stall [2];
  logic [15:0] pdata [2];
  logic [7:0]  pidx [2];
  logic        plast [2];
  int          frames_done [2];
  int          ovr_cnt [2];

  always #5 CLK = ~CLK;

  frame_reader #(.ADDR_W(8), .DATA_W(16), .BIT_REVERSE(1)) u_rev (
    .CLK(CLK), .RESET(RESET), .FRAME_READY(FRAME_READY), .RADDR(r_raddr), .RE(r_re),
    .RDATA(r_rdata), .DATA_OUT(r_dout), .DV(r_dv), .READY(READY), .INDEX(r_index),
    .LAST(r_last), .BUSY(r_busy), .OVERRUN(r_ovr)
  );

  frame_reader #(.ADDR_W(8), .DATA_W(16), .BIT_REVERSE(0)) u_nat (
    .CLK(CLK), .RESET(RESET), .FRAME_READY(FRAME_READY), .RADDR(n_raddr), .RE(n_re),
    .RDATA(n_rdata), .DATA_OUT(n_dout), .DV(n_dv), .READY(READY), .INDEX(n_index),
    .LAST(n_last), .BUSY(n_busy), .OVERRUN(n_ovr)
  );

  // Synchronous-read RAM models: data one cycle after RE.
  always @(posedge CLK) if (r_re) r_rdata <= mem[r_raddr];
  always @(posedge CLK) if (n_re) n_rdata <= mem[n_raddr];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int bitrev8(input int v);
    int r = 0;
    int x = v;
    for (int b = 0; b < 8; b++) begin
      r = r * 2 + x % 2;
      x = x / 2;
    end
    return r;
  endfunction

  function automatic logic [15:0] exp_data(input int k, input int i);
    return (k == 0) ? mem[bitrev8(i)] : mem[i];
  endfunction

  // Scoreboard: every accepted sample must be the next natural index of the frame.
  task automatic mon(input int k, input logic dv, input logic [15:0] data,
                     input logic [7:0] idx, input logic last, input logic ovr);
    if (RESET) begin
      exp_idx[k] = 0;
      stall[k]   = 1'b0;
      return;
    end
    if (stall[k]) begin
      chk("stall_dv", 32'(dv), 32'd1);
      chk("stall_data", 32'(data), 32'(pdata[k]));
      chk("stall_index", 32'(idx), 32'(pidx[k]));
      chk("stall_last", 32'(last), 32'(plast[k]));
    end
    if (dv && READY) begin
      chk(k == 0 ? "rev_index" : "nat_index", 32'(idx), 32'(exp_idx[k]));
      chk(k == 0 ? "rev_data" : "nat_data", 32'(data), 32'(exp_data(k, exp_idx[k])));
      chk("last_flag", 32'(last), 32'(exp_idx[k] == 255));
      if (exp_idx[k] == 255) begin
        frames_done[k]++;
        exp_idx[k] = 0;
      end else begin
        exp_idx[k]++;
      end
    end
    stall[k] = dv && !READY;
    pdata[k] = data;
    pidx[k]  = idx;
    plast[k] = last;
    if (ovr) ovr_cnt[k]++;
  endtask

  always @(negedge CLK) begin
    mon(0, r_dv, r_dout, r_index, r_last, r_ovr);
    mon(1, n_dv, n_dout, n_index, n_last, n_ovr);
  end

  task automatic step();
    @(posedge CLK);
    #1;
    if (ready_mode == 1) READY = ~READY;
    else if (ready_mode == 2) READY = ($urandom_range(0, 3) != 0);
  endtask

  task automatic sample();
    @(negedge CLK);
    #1;
  endtask

  // Entered just after a clock edge; returns at the sample point of the hit cycle.
  task automatic wait_xfer_idx(input int idx);
    logic hit = 1'b0;
    for (int n = 0; n < 4000; n++) begin
      sample();
      if (r_dv && READY && (32'(r_index) == idx)) begin
        hit = 1'b1;
        break;
      end
      step();
    end
    chk("wait_index_reached", 32'(hit), 32'd1);
  endtask

  task automatic wait_frame(input int target);
    for (int n = 0; n < 4000; n++) begin
      sample();
      if (frames_done[0] >= target) break;
      step();
    end
    chk("frames_rev", 32'(frames_done[0]), 32'(target));
    chk("frames_nat", 32'(frames_done[1]), 32'(target));
  endtask

  task automatic chk_reset_outputs();
    chk("rst_re", 32'(r_re), 32'd0);
    chk("rst_raddr", 32'(r_raddr), 32'd0);
    chk("rst_dv", 32'(r_dv), 32'd0);
    chk("rst_data", 32'(r_dout), 32'd0);
    chk("rst_index", 32'(r_index), 32'd0);
    chk("rst_last", 32'(r_last), 32'd0);
    chk("rst_busy", 32'(r_busy), 32'd0);
    chk("rst_overrun", 32'(r_ovr), 32'd0);
    chk("rst_nat_dv", 32'(n_dv), 32'd0);
    chk("rst_nat_busy", 32'(n_busy), 32'd0);
    chk("rst_nat_raddr", 32'(n_raddr), 32'd0);
  endtask

  initial begin
    int dvc;
    int re_cnt;
    for (int k = 0; k < 2; k++) begin
      exp_idx[k] = 0; stall[k] = 1'b0; frames_done[k] = 0; ovr_cnt[k] = 0;
    end
    for (int a = 0; a < 256; a++) mem[a] = 16'(a);
    RESET = 1'b1;
    FRAME_READY = 1'b0;
    READY = 1'b1;
    repeat (3) step();
    RESET = 1'b0;
    sample();
    chk_reset_outputs();

    // Latency and full-rate throughput.
    step(); FRAME_READY = 1'b1;
    step(); FRAME_READY = 1'b0;
    sample();
    chk("c1_re", 32'(r_re), 32'd1);
    chk("c1_raddr", 32'(r_raddr), 32'd0);
    chk("c1_busy", 32'(r_busy), 32'd1);
    chk("c1_dv", 32'(r_dv), 32'd0);
    step(); sample();
    chk("c2_raddr_rev", 32'(r_raddr), 32'd128);
    chk("c2_raddr_nat", 32'(n_raddr), 32'd1);
    chk("c2_dv", 32'(r_dv), 32'd0);
    step(); sample();
    chk("c3_dv", 32'(r_dv), 32'd1);
    chk("c3_index", 32'(r_index), 32'd0);
    chk("c3_data", 32'(r_dout), 32'd0);
    dvc = 0;
    repeat (255) begin
      step(); sample();
      dvc += int'(r_dv && READY);
    end
    chk("rate_dv_cycles", 32'(dvc), 32'd255);
    chk("rate_last", 32'(r_last), 32'd1);
    chk("rate_last_index", 32'(r_index), 32'd255);
    step(); sample();
    chk("after_last_busy", 32'(r_busy), 32'd0);
    chk("after_last_dv", 32'(r_dv), 32'd0);
    chk("frame1_done", 32'(frames_done[0]), 32'd1);

    // Alternating READY.
    ready_mode = 1;
    step(); FRAME_READY = 1'b1;
    step(); FRAME_READY = 1'b0;
    wait_frame(2);
    ready_mode = 0;
    step(); READY = 1'b1;
    sample();

    // Consumer stalled from the start: only two reads may be outstanding.
    READY = 1'b0;
    step(); FRAME_READY = 1'b1;
    step(); FRAME_READY = 1'b0;
    re_cnt = 0;
    repeat (20) begin
      sample();
      re_cnt += int'(r_re) + int'(n_re);
      step();
    end
    chk("stall_reads_issued", 32'(re_cnt), 32'd4);
    sample();
    chk("stall_dv_held", 32'(r_dv), 32'd1);
    chk("stall_index0", 32'(r_index), 32'd0);
    step(); READY = 1'b1; ready_mode = 2;
    wait_frame(3);

    // Queued request then a dropped one.
    step(); FRAME_READY = 1'b1;
    step(); FRAME_READY = 1'b0;
    wait_xfer_idx(100);
    step(); FRAME_READY = 1'b1;
    step(); FRAME_READY = 1'b0;
    sample();
    chk("pend_no_overrun", 32'(r_ovr), 32'd0);
    chk("pend_busy", 32'(r_busy), 32'd1);
    step();
    wait_xfer_idx(150);
    step(); FRAME_READY = 1'b1;
    step(); FRAME_READY = 1'b0;
    sample();
    chk("drop_overrun", 32'(r_ovr), 32'd1);
    step();
    wait_xfer_idx(255);
    step(); sample();
    chk("restart_busy", 32'(r_busy), 32'd1);
    chk("restart_re", 32'(r_re), 32'd1);
    chk("restart_raddr", 32'(r_raddr), 32'd0);
    step();
    wait_frame(5);
    chk("overrun_count_rev", 32'(ovr_cnt[0]), 32'd1);
    chk("overrun_count_nat", 32'(ovr_cnt[1]), 32'd1);

    // Request coincident with the last transfer.
    ready_mode = 0;
    step(); READY = 1'b1;
    step(); FRAME_READY = 1'b1;
    step(); FRAME_READY = 1'b0;
    wait_xfer_idx(254);
    step(); FRAME_READY = 1'b1;
    sample();
    chk("coinc_last", 32'(r_last), 32'd1);
    chk("coinc_ready", 32'(READY), 32'd1);
    step(); FRAME_READY = 1'b0;
    sample();
    chk("coinc_busy", 32'(r_busy), 32'd1);
    chk("coinc_re", 32'(r_re), 32'd1);
    chk("coinc_no_overrun", 32'(r_ovr), 32'd0);
    step(); sample();
    chk("coinc_dv_c2", 32'(r_dv), 32'd0);
    step(); sample();
    chk("coinc_dv_c3", 32'(r_dv), 32'd1);
    chk("coinc_index0", 32'(r_index), 32'd0);
    step();
    wait_frame(7);
    chk("coinc_overrun_count", 32'(ovr_cnt[0]), 32'd1);

    // Random RAM contents, reset mid-frame, then a clean frame.
    step(); sample();
    for (int a = 0; a < 256; a++) mem[a] = 16'($urandom);
    ready_mode = 2;
    step(); FRAME_READY = 1'b1;
    step(); FRAME_READY = 1'b0;
    wait_xfer_idx(50);
    step(); RESET = 1'b1; FRAME_READY = 1'b1;
    step(); RESET = 1'b0; FRAME_READY = 1'b0;
    sample();
    chk_reset_outputs();
    repeat (3) begin
      step(); sample();
      chk("post_rst_busy", 32'(r_busy), 32'd0);
      chk("post_rst_dv", 32'(r_dv | n_dv), 32'd0);
    end
    step(); FRAME_READY = 1'b1;
    step(); FRAME_READY = 1'b0;
    wait_frame(8);
    step(); sample();
    ready_mode = 0;
    step(); sample();
    chk("final_busy", 32'(r_busy | n_busy), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/frame_reader.md
FRAME_READER -- requirements
Module: frame_reader

Interface
REQ-001 Parameter ADDR_W, default 8, sample-RAM address width; a frame holds 2^ADDR_W samples.
REQ-002 Parameter DATA_W, default 16, sample width, matching the ADC sample word.
REQ-003 Parameter BIT_REVERSE, default 1; 1 = read frame in bit-reversed address order for FFT input, 0 = natural order.
REQ-004 CLK  in  1  system clock (16 MHz); the block SHALL have one clock; reset is synchronous and active-high.
REQ-005 RESET  in  1  synchronous, active-high reset.
REQ-006 FRAME_READY  in  1  one-cycle pulse from the write side: a full frame is in RAM.
REQ-007 RADDR  out  ADDR_W  read address to SB_RAM40_4K RADDR.
REQ-008 RE  out  1  read enable to RAM RE/RCLKE; RCLK = CLK.
REQ-009 RDATA  in  DATA_W  RAM read data, valid exactly one cycle after a cycle with RE=1.
REQ-010 DATA_OUT  out  DATA_W  sample to the downstream consumer.
REQ-011 DV  out  1  DATA_OUT valid.
REQ-012 READY  in  1  consumer accepts; a transfer occurs on a cycle with DV=1 and READY=1.
REQ-013 INDEX  out  ADDR_W  natural-order sample number (0..2^ADDR_W-1) of DATA_OUT.
REQ-014 LAST  out  1  high with DV when INDEX = 2^ADDR_W-1.
REQ-015 BUSY  out  1  high from frame start until the LAST transfer.
REQ-016 OVERRUN  out  1  one-cycle pulse when a frame request is dropped.

Function
REQ-017 FSM states SHALL be IDLE, READ (issuing RAM reads), DRAIN (all reads issued, buffered samples outstanding).
REQ-018 IDLE -> READ on FRAME_READY=1 or pending flag set; read counter cleared to 0; BUSY=1 from the next cycle.
REQ-019 READ: RE=1 and RADDR = bitrev(count) (BIT_REVERSE=1) or count (0) whenever occupancy + in-flight reads − (this-cycle transfer) < 2; count increments per issued read.
REQ-020 READ -> DRAIN after the read with count = 2^ADDR_W-1 is issued; count SHALL NOT wrap into a new frame.
REQ-021 DRAIN -> IDLE (or READ if pending) on the LAST transfer; BUSY falls the cycle after LAST is accepted unless pending.
REQ-022 Output SHALL use a 2-entry skid buffer; RDATA captured the cycle after RE; no sample lost or duplicated under any READY pattern.
REQ-023 Latency: FRAME_READY sampled in cycle 0 -> RE in cycle 1 -> DV=1 with INDEX=0 in cycle 3.
REQ-024 With READY held high, throughput SHALL be one sample per cycle: 2^ADDR_W transfers in 2^ADDR_W consecutive cycles.
REQ-025 DATA_OUT, INDEX, LAST SHALL hold stable while DV=1 and READY=0.
REQ-026 FRAME_READY while BUSY and no pending: set pending; frame restarts the cycle after the LAST transfer.
REQ-027 FRAME_READY while pending already set: OVERRUN pulses next cycle; request dropped; pending unchanged.
REQ-028 FRAME_READY on the same cycle as the LAST transfer SHALL set pending (not overrun).

Reset
REQ-029 RESET SHALL force state IDLE, count 0, pending 0, buffer empty, and on the next cycle RE=0, RADDR=0, DV=0, DATA_OUT=0, INDEX=0, LAST=0, BUSY=0, OVERRUN=0.
REQ-030 RESET mid-frame SHALL abandon the frame; RDATA returning after reset SHALL be discarded; FRAME_READY during RESET SHALL be ignored.

Structure
REQ-031 Shared package SHALL hold ADDR_W/DATA_W defaults, frame length constant, and FSM state encoding.
REQ-032 One sub-module, skid_buffer (2-entry, DATA_W+ADDR_W+1 wide), SHALL implement REQ-022/REQ-025; bit reversal is inline.

Verification
REQ-033 ADDR_W=8, BIT_REVERSE=1, READY=1, RAM preloaded mem[a]=a: FRAME_READY pulse -> DV cycle 3, 256 transfers, DATA_OUT sequence 0,128,64,192,..., LAST with INDEX=255.
REQ-034 BIT_REVERSE=0, READY toggling 1/0 per cycle -> DATA_OUT = 0..255 in order, no gaps or repeats, outputs stable while stalled.
REQ-035 FRAME_READY at INDEX=100, again at INDEX=150 -> second frame starts right after LAST; OVERRUN pulses once for the third request.
REQ-036 READY=0 for 20 cycles at start -> RE stops after 2 reads in flight/buffered; resumption yields INDEX 0,1,2...
REQ-037 RESET asserted at INDEX=50 -> next cycle all outputs at reset values; new FRAME_READY restarts at INDEX=0.
REQ-038 FRAME_READY coincident with LAST transfer -> no OVERRUN, BUSY stays high, next frame DV with INDEX=0.
